// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT coefficient datapath.
// Rounding in the scale stage is selected by the DCT_COEF_MAC_ROUND_EN macro.
package dct_pkg;

  localparam int PIX_W       = 8;
  localparam int COS_W       = 32;
  localparam int FRAC_BITS   = 8;
  localparam int ACC_W       = 32;
  localparam int OUT_W       = 16;
  localparam int N           = 8;
  localparam int LEVEL_SHIFT = 128;

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [COS_W-1:0] cos_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/dct_scale_sat.sv
// Fixed-point scale (arithmetic shift by FRAC_BITS) and saturation to coef_t.
// With DCT_COEF_MAC_ROUND_EN defined, half an LSB is added before the shift.
module dct_scale_sat
  import dct_pkg::*;
(
  input  acc_t  acc_i,
  output coef_t coef_o
);

  localparam acc_t COEF_MAX = acc_t'((1 << (OUT_W - 1)) - 1);
  localparam acc_t COEF_MIN = -acc_t'(1 << (OUT_W - 1));

  acc_t biased_d;
  acc_t shifted_d;

  always_comb begin
`ifdef DCT_COEF_MAC_ROUND_EN
    biased_d = acc_i + acc_t'(1 << (FRAC_BITS - 1));
`else
    biased_d = acc_i;
`endif
    shifted_d = biased_d >>> FRAC_BITS;
    if (shifted_d > COEF_MAX) begin
      coef_o = coef_t'(COEF_MAX);
    end else if (shifted_d < COEF_MIN) begin
      coef_o = coef_t'(COEF_MIN);
    end else begin
      coef_o = coef_t'(shifted_d);
    end
  end

endmodule

// File: rtl/dct_coef_mac.sv
// Sequential MAC producing one 8x8 DCT coefficient (k1,k2) from pixel RAM and cosine LUT.
// Output rounding is selected by DCT_COEF_MAC_ROUND_EN (see dct_scale_sat).
module dct_coef_mac
  import dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] k1,
  input  logic [2:0] k2,
  output logic       busy,
  output logic [2:0] lut_k1,
  output logic [2:0] lut_k2,
  output logic [2:0] lut_n1,
  output logic [2:0] lut_n2,
  input  cos_t       cos_term,
  output logic [5:0] pix_addr,
  input  pix_t       pix_rdata,
  output coef_t      coef,
  output logic       coef_valid,
  input  logic       coef_ready
);

  localparam logic [5:0] IDX_LAST = 6'(N * N - 1);

  state_t     state_q;
  logic [2:0] k1_q, k2_q;
  logic [5:0] idx_q;
  cos_t       cos_q;
  logic       v1_q;
  acc_t       prod_q;
  logic       v2_q;
  acc_t       acc_q;
  logic       first_q;
  coef_t      coef_q;
  logic       coef_valid_q;

  logic [PIX_W:0] pix_ls_d;
  acc_t           prod_d;
  coef_t          coef_d;

  // Level shift in unsigned arithmetic; the 9-bit result reinterpreted as signed is pix-128.
  assign pix_ls_d = {1'b0, pix_rdata} - (PIX_W + 1)'(LEVEL_SHIFT);
  assign prod_d   = acc_t'($signed(pix_ls_d)) * acc_t'(cos_q);

  dct_scale_sat u_scale_sat (
    .acc_i  (acc_q),
    .coef_o (coef_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k1_q         <= '0;
      k2_q         <= '0;
      idx_q        <= '0;
      cos_q        <= '0;
      v1_q         <= 1'b0;
      prod_q       <= '0;
      v2_q         <= 1'b0;
      acc_q        <= '0;
      first_q      <= 1'b0;
      coef_q       <= '0;
      coef_valid_q <= 1'b0;
    end else begin
      v1_q   <= 1'b0;
      v2_q   <= v1_q;
      prod_q <= prod_d;
      if (v2_q) begin
        acc_q   <= first_q ? prod_q : acc_q + prod_q;
        first_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k1_q    <= k1;
            k2_q    <= k2;
            idx_q   <= '0;
            first_q <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          cos_q <= cos_term;
          v1_q  <= 1'b1;
          idx_q <= idx_q + 6'd1;
          if (idx_q == IDX_LAST) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Both pipeline stages empty means the last product is already in acc_q.
          if (!v1_q && !v2_q) begin
            coef_q       <= coef_d;
            coef_valid_q <= 1'b1;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (coef_ready) begin
            coef_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign lut_k1     = k1_q;
  assign lut_k2     = k2_q;
  assign lut_n1     = idx_q[5:3];
  assign lut_n2     = idx_q[2:0];
  assign pix_addr   = idx_q;
  assign coef       = coef_q;
  assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_dct_coef_mac.sv
// Self-checking bench for dct_coef_mac: LUT and pixel RAM models, arithmetic reference, corner sequences.
module tb_dct_coef_mac;
  import dct_pkg::*;

`ifdef DCT_COEF_MAC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] k1, k2;
  logic       busy;
  logic [2:0] lut_k1, lut_k2, lut_n1, lut_n2;
  cos_t       cos_term;
  logic [5:0] pix_addr;
  pix_t       pix_rdata;
  coef_t      coef;
  logic       coef_valid;
  logic       coef_ready;

  acc_t  sat_acc;
  coef_t sat_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] pix_mem [64];

  // round(256*cos((2n+1)k*pi/16)), indexed [k][n]
  int c1 [8][8] = '{
    '{256, 256, 256, 256, 256, 256, 256, 256},
    '{251, 213, 142, 50, -50, -142, -213, -251},
    '{237, 98, -98, -237, -237, -98, 98, 237},
    '{213, -50, -251, -142, 142, 251, 50, -213},
    '{181, -181, -181, 181, 181, -181, -181, 181},
    '{142, -251, 50, 213, -213, -50, 251, -142},
    '{98, -237, 237, -98, -98, 237, -237, 98},
    '{50, -142, 213, -251, 251, -213, 142, -50}
  };

  typedef struct {
    longint acc;
    int     exp_t;
    int     exp_r;
  } sat_vec_t;

  sat_vec_t vecs [14];

  dct_coef_mac dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k1         (k1),
    .k2         (k2),
    .busy       (busy),
    .lut_k1     (lut_k1),
    .lut_k2     (lut_k2),
    .lut_n1     (lut_n1),
    .lut_n2     (lut_n2),
    .cos_term   (cos_term),
    .pix_addr   (pix_addr),
    .pix_rdata  (pix_rdata),
    .coef       (coef),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready)
  );

  dct_scale_sat u_sat (
    .acc_i  (sat_acc),
    .coef_o (sat_out)
  );

  always #5 clk = ~clk;

  function automatic int lut_val(int a1, int a2, int n1, int n2);
    int a, b, m;
    a = c1[a1][n1];
    b = c1[a2][n2];
    m = ((a < 0 ? -a : a) * (b < 0 ? -b : b)) >> 8;
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  always_comb cos_term = lut_val(int'(lut_k1), int'(lut_k2), int'(lut_n1), int'(lut_n2));

  always @(posedge clk) pix_rdata <= pix_mem[pix_addr];

  function automatic longint sat_ref(longint s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic longint model_coef(int a1, int a2);
    longint acc = 0;
    for (int i = 0; i < 64; i++)
      acc += longint'(int'(pix_mem[i]) - 128) * longint'(lut_val(a1, a2, i / 8, i % 8));
    if (ROUND) acc += 128;
    return sat_ref(acc >>> 8);
  endfunction

  task automatic check(string name, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_start(int a1, int a2);
    @(negedge clk);
    start = 1'b1;
    k1 = 3'(a1);
    k2 = 3'(a2);
    @(negedge clk);
    start = 1'b0;
    k1 = 3'($urandom);
    k2 = 3'($urandom);
    check("busy_after_start", longint'(busy), 1);
    check("lut_k1_latched", longint'(lut_k1), a1);
    check("lut_k2_latched", longint'(lut_k2), a2);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!coef_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept(int delay);
    repeat (delay) @(negedge clk);
    coef_ready = 1'b1;
    @(negedge clk);
    coef_ready = 1'b0;
    check("valid_drop_after_accept", longint'(coef_valid), 0);
    check("idle_after_accept", longint'(busy), 0);
  endtask

  task automatic run_and_check(string nm, int a1, int a2, int delay, longint exp);
    int cyc;
    do_start(a1, a2);
    wait_valid(cyc);
    check("latency_cycle", cyc, 68);
    check(nm, longint'(coef), exp);
    accept(delay);
  endtask

  initial begin
    int cyc;
    coef_t held;
    reset = 1'b1;
    start = 1'b0;
    k1 = '0;
    k2 = '0;
    coef_ready = 1'b0;
    sat_acc = '0;
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'd128;

    vecs[0]  = '{-129, -1, -1};
    vecs[1]  = '{128, 0, 1};
    vecs[2]  = '{127, 0, 0};
    vecs[3]  = '{-128, -1, 0};
    vecs[4]  = '{0, 0, 0};
    vecs[5]  = '{255, 0, 1};
    vecs[6]  = '{256, 1, 1};
    vecs[7]  = '{-257, -2, -1};
    vecs[8]  = '{8388607, 32767, 32767};
    vecs[9]  = '{8388608, 32767, 32767};
    vecs[10] = '{-8388608, -32768, -32768};
    vecs[11] = '{-8388609, -32768, -32768};
    vecs[12] = '{16777216, 32767, 32767};
    vecs[13] = '{-16777216, -32768, -32768};

    for (int i = 0; i < 14; i++) begin
      sat_acc = acc_t'(vecs[i].acc);
      #1;
      check($sformatf("scale_sat[%0d]", i), longint'(sat_out), ROUND ? vecs[i].exp_r : vecs[i].exp_t);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", longint'(busy), 0);
    check("rst_valid", longint'(coef_valid), 0);
    check("rst_coef", longint'(coef), 0);
    check("rst_lut_k", longint'({lut_k1, lut_k2}), 0);
    check("rst_lut_n", longint'({lut_n1, lut_n2}), 0);
    check("rst_pix_addr", longint'(pix_addr), 0);

    run_and_check("flat128_k42", 4, 2, 0, 0);

    for (int i = 0; i < 64; i++) pix_mem[i] = 8'd255;
    run_and_check("all255_k00", 0, 0, 1, 8128);
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'd0;
    run_and_check("all0_k00", 0, 0, 0, -8192);

    for (int i = 0; i < 64; i++)
      pix_mem[i] = (lut_val(4, 2, i / 8, i % 8) > 0) ? 8'd138 : 8'd118;
    run_and_check("sign_pattern_k42", 4, 2, 2, 295);

    // Back-pressure: output held stable and start pulses ignored.
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom);
    do_start(3, 5);
    wait_valid(cyc);
    check("hold_latency", cyc, 68);
    check("hold_coef", longint'(coef), model_coef(3, 5));
    held = coef;
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      k1 = 3'($urandom);
      k2 = 3'($urandom);
      @(negedge clk);
      check("hold_coef_stable", longint'(coef), longint'(held));
      check("hold_valid_stable", longint'(coef_valid), 1);
      check("hold_k1_stable", longint'(lut_k1), 3);
    end
    coef_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    coef_ready = 1'b0;
    start = 1'b0;
    check("handshake_valid_drop", longint'(coef_valid), 0);
    check("handshake_start_ignored", longint'(busy), 0);
    check("coef_kept_after_accept", longint'(coef), longint'(held));

    // Reset in the middle of a run.
    do_start(1, 6);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_busy", longint'(busy), 0);
    check("midrun_reset_valid", longint'(coef_valid), 0);
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom);
    run_and_check("after_reset", 1, 6, 0, model_coef(1, 6));

    for (int t = 0; t < 10; t++) begin
      int a1, a2;
      a1 = int'($urandom_range(0, 7));
      a2 = int'($urandom_range(0, 7));
      for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom);
      run_and_check($sformatf("rand_k%0d%0d", a1, a2), a1, a2, int'($urandom_range(0, 3)),
                    model_coef(a1, a2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
